pio_ctrl_regfile_v2: RTL and testbench

Parametrised processor-facing control/status register file for the PIO block, successor to the fixed four-state-machine regfile. Decodes byte-addressed word writes and reads. Implements RW, RO, write-1-clear (WC) and self-clearing (SC) fields, with defined reset values. Adds a registered read port with valid handshake, an instruction-injection strobe and interrupt aggregation to two IRQ lines. Sits between the bus slave adapter and the state machines/FIFOs.

---
 rtl/pio_ctrl_regfile_v2.sv | 194 +++++++++++++++++++
 tb/tb_pio_ctrl_regfile_v2.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_ctrl_regfile_v2.sv
// PIO control/status register file: RW/RO/WC/SC fields, 1-cycle registered read port, IRQ aggregation.
// Define PIO_REGFILE_WRERR_EN to add wr_err and the sticky DBG_CFGINFO[31] bad-write flag.
module pio_ctrl_regfile_v2 #(
  parameter int NUM_SM = 4,
  parameter int ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic [NUM_SM-1:0]     sm_en,
  output logic [NUM_SM-1:0]     sm_restart,
  output logic [NUM_SM-1:0]     clkdiv_restart,
  input  logic [NUM_SM-1:0]     tx_empty,
  input  logic [NUM_SM-1:0]     tx_full,
  input  logic [NUM_SM-1:0]     rx_empty,
  input  logic [NUM_SM-1:0]     rx_full,
  input  logic [NUM_SM-1:0]     tx_stall,
  input  logic [NUM_SM-1:0]     tx_over,
  input  logic [NUM_SM-1:0]     rx_under,
  input  logic [NUM_SM-1:0]     rx_stall,
  input  logic [8*NUM_SM-1:0]   flevel,
  input  logic [7:0]            irq_set,
  input  logic [7:0]            irq_clr,
  output logic [31:0]           gpio_sync_bypass,
  output logic [32*NUM_SM-1:0]  sm_clkdiv,
  output logic [32*NUM_SM-1:0]  sm_execctrl,
  output logic [32*NUM_SM-1:0]  sm_shiftctrl,
  output logic [32*NUM_SM-1:0]  sm_pinctrl,
  output logic [16*NUM_SM-1:0]  sm_instr,
  output logic [NUM_SM-1:0]     sm_instr_wr,
`ifdef PIO_REGFILE_WRERR_EN
  output logic                  wr_err,
`endif
  output logic [1:0]            irq_out
);

  // Word addresses (byte address >> 2)
  localparam int A_CTRL = 0, A_FSTAT = 1, A_FDEBUG = 2, A_FLEVEL = 3;
  localparam int A_IRQ = 12, A_BYP = 14, A_DBG = 17, A_SM0 = 50;
  localparam int A_INTR = 74, A_INTE0 = 75, A_INTF0 = 76, A_INTS0 = 77;
  localparam int A_INTE1 = 78, A_INTF1 = 79, A_INTS1 = 80;
  localparam logic [3:0] SM_MASK = 4'((1 << NUM_SM) - 1);

  int wr_word, rd_word;
  assign wr_word = int'(wr_addr[ADDR_W-1:2]);
  assign rd_word = int'(rd_addr[ADDR_W-1:2]);

  logic [NUM_SM-1:0] fd_txst, fd_txov, fd_rxun, fd_rxst;
  logic [7:0]        irq_q;
  logic [11:0]       inte0, intf0, inte1, intf1, intr, ints0, ints1;
  logic              dbg_err;
  logic [31:0]       rd_mux;

  logic w_ctrl, w_fdebug, w_irq, w_byp, w_inte0, w_intf0, w_inte1, w_intf1, w_dbg, wr_ok;
  logic [NUM_SM-1:0] w_clkdiv, w_exec, w_shift, w_instr, w_pin;

  assign intr  = {irq_q[3:0], ~4'(tx_full) & SM_MASK, ~4'(rx_empty) & SM_MASK};
  assign ints0 = (intr | intf0) & inte0;
  assign ints1 = (intr | intf1) & inte1;

  always_comb begin
    w_ctrl = 1'b0; w_fdebug = 1'b0; w_irq = 1'b0; w_byp = 1'b0; w_dbg = 1'b0;
    w_inte0 = 1'b0; w_intf0 = 1'b0; w_inte1 = 1'b0; w_intf1 = 1'b0; wr_ok = 1'b0;
    w_clkdiv = '0; w_exec = '0; w_shift = '0; w_instr = '0; w_pin = '0;
    if (wr_en) begin
      case (wr_word)
        A_CTRL:   begin w_ctrl   = 1'b1; wr_ok = 1'b1; end
        A_FDEBUG: begin w_fdebug = 1'b1; wr_ok = 1'b1; end
        A_IRQ:    begin w_irq    = 1'b1; wr_ok = 1'b1; end
        A_BYP:    begin w_byp    = 1'b1; wr_ok = 1'b1; end
        A_DBG:    begin w_dbg    = 1'b1; wr_ok = 1'b1; end
        A_INTE0:  begin w_inte0  = 1'b1; wr_ok = 1'b1; end
        A_INTF0:  begin w_intf0  = 1'b1; wr_ok = 1'b1; end
        A_INTE1:  begin w_inte1  = 1'b1; wr_ok = 1'b1; end
        A_INTF1:  begin w_intf1  = 1'b1; wr_ok = 1'b1; end
        default: ;
      endcase
      // SMn ADDR (offset 3) is read-only and therefore not a valid write target
      for (int i = 0; i < NUM_SM; i++) begin
        case (wr_word - (A_SM0 + 6 * i))
          0: begin w_clkdiv[i] = 1'b1; wr_ok = 1'b1; end
          1: begin w_exec[i]   = 1'b1; wr_ok = 1'b1; end
          2: begin w_shift[i]  = 1'b1; wr_ok = 1'b1; end
          4: begin w_instr[i]  = 1'b1; wr_ok = 1'b1; end
          5: begin w_pin[i]    = 1'b1; wr_ok = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_word)
      A_CTRL:   rd_mux = {28'b0, 4'(sm_en)};
      A_FSTAT:  rd_mux = {4'b0, 4'(tx_empty), 4'b0, 4'(tx_full), 4'b0, 4'(rx_empty), 4'b0, 4'(rx_full)};
      A_FDEBUG: rd_mux = {4'b0, 4'(fd_txst), 4'b0, 4'(fd_txov), 4'b0, 4'(fd_rxun), 4'b0, 4'(fd_rxst)};
      A_FLEVEL: rd_mux = 32'(flevel);
      A_IRQ:    rd_mux = {24'b0, irq_q};
      A_BYP:    rd_mux = gpio_sync_bypass;
      A_DBG:    rd_mux = {dbg_err, 25'b0, 6'(NUM_SM)};
      A_INTR:   rd_mux = {20'b0, intr};
      A_INTE0:  rd_mux = {20'b0, inte0};
      A_INTF0:  rd_mux = {20'b0, intf0};
      A_INTS0:  rd_mux = {20'b0, ints0};
      A_INTE1:  rd_mux = {20'b0, inte1};
      A_INTF1:  rd_mux = {20'b0, intf1};
      A_INTS1:  rd_mux = {20'b0, ints1};
      default: ;
    endcase
    for (int i = 0; i < NUM_SM; i++) begin
      case (rd_word - (A_SM0 + 6 * i))
        0: rd_mux = sm_clkdiv[32*i +: 32];
        1: rd_mux = sm_execctrl[32*i +: 32];
        2: rd_mux = sm_shiftctrl[32*i +: 32];
        4: rd_mux = {16'b0, sm_instr[16*i +: 16]};
        5: rd_mux = sm_pinctrl[32*i +: 32];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sm_en <= '0; sm_restart <= '0; clkdiv_restart <= '0; sm_instr_wr <= '0;
      fd_txst <= '0; fd_txov <= '0; fd_rxun <= '0; fd_rxst <= '0;
      irq_q <= '0; gpio_sync_bypass <= '0;
      inte0 <= '0; intf0 <= '0; inte1 <= '0; intf1 <= '0;
      irq_out <= '0; rd_valid <= 1'b0; rd_data <= '0;
      for (int i = 0; i < NUM_SM; i++) begin
        sm_clkdiv[32*i +: 32]    <= 32'h0001_0000;
        sm_execctrl[32*i +: 32]  <= 32'h0001_F000;
        sm_shiftctrl[32*i +: 32] <= 32'h000C_0000;
        sm_pinctrl[32*i +: 32]   <= 32'h1400_0000;
        sm_instr[16*i +: 16]     <= '0;
      end
    end else begin
      if (w_ctrl) sm_en <= wr_data[NUM_SM-1:0];
      sm_restart     <= w_ctrl ? wr_data[4 +: NUM_SM] : '0;
      clkdiv_restart <= w_ctrl ? wr_data[8 +: NUM_SM] : '0;
      // Sticky events: a same-cycle event beats the software clear
      fd_txst <= (fd_txst & ~(w_fdebug ? wr_data[24 +: NUM_SM] : '0)) | tx_stall;
      fd_txov <= (fd_txov & ~(w_fdebug ? wr_data[16 +: NUM_SM] : '0)) | tx_over;
      fd_rxun <= (fd_rxun & ~(w_fdebug ? wr_data[8 +: NUM_SM] : '0)) | rx_under;
      fd_rxst <= (fd_rxst & ~(w_fdebug ? wr_data[0 +: NUM_SM] : '0)) | rx_stall;
      irq_q   <= (irq_q & ~irq_clr & ~(w_irq ? wr_data[7:0] : 8'h00)) | irq_set;
      if (w_byp)   gpio_sync_bypass <= wr_data;
      if (w_inte0) inte0 <= wr_data[11:0];
      if (w_intf0) intf0 <= wr_data[11:0];
      if (w_inte1) inte1 <= wr_data[11:0];
      if (w_intf1) intf1 <= wr_data[11:0];
      for (int i = 0; i < NUM_SM; i++) begin
        if (w_clkdiv[i]) sm_clkdiv[32*i +: 32]    <= wr_data & 32'hFFFF_FF00;
        if (w_exec[i])   sm_execctrl[32*i +: 32]  <= wr_data & 32'h7FFF_FF9F;
        if (w_shift[i])  sm_shiftctrl[32*i +: 32] <= wr_data & 32'hFFFF_0000;
        if (w_pin[i])    sm_pinctrl[32*i +: 32]   <= wr_data;
        if (w_instr[i])  sm_instr[16*i +: 16]     <= wr_data[15:0];
      end
      sm_instr_wr <= w_instr;
      irq_out     <= {|ints1, |ints0};
      rd_valid    <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

`ifdef PIO_REGFILE_WRERR_EN
  logic wr_bad;
  assign wr_bad = wr_en & ~wr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err  <= 1'b0;
      dbg_err <= 1'b0;
    end else begin
      wr_err  <= wr_bad;
      dbg_err <= (dbg_err & ~(w_dbg & wr_data[31])) | wr_bad;
    end
  end
`else
  logic unused_wrerr;
  assign dbg_err      = 1'b0;
  assign unused_wrerr = ^{w_dbg, wr_ok};
`endif

  logic unused_addr;
  assign unused_addr = ^{wr_addr[1:0], rd_addr[1:0]};

endmodule

// File: tb/tb_pio_ctrl_regfile_v2.sv
// Scoreboard bench for pio_ctrl_regfile_v2 (NUM_SM=4); read results are queued at request time.
module tb_pio_ctrl_regfile_v2;
  localparam int NSM = 4;
  localparam int AW  = 9;

  logic clk = 1'b0;
  logic rst, wr_en, rd_en, rd_valid;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data, gpio_sync_bypass;
  logic [NSM-1:0] sm_en, sm_restart, clkdiv_restart, sm_instr_wr;
  logic [NSM-1:0] tx_empty, tx_full, rx_empty, rx_full;
  logic [NSM-1:0] tx_stall, tx_over, rx_under, rx_stall;
  logic [8*NSM-1:0] flevel;
  logic [7:0] irq_set, irq_clr;
  logic [32*NSM-1:0] sm_clkdiv, sm_execctrl, sm_shiftctrl, sm_pinctrl;
  logic [16*NSM-1:0] sm_instr;
  logic [1:0] irq_out;
`ifdef PIO_REGFILE_WRERR_EN
  logic wr_err;
`endif

  pio_ctrl_regfile_v2 #(.NUM_SM(NSM), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .sm_en(sm_en), .sm_restart(sm_restart), .clkdiv_restart(clkdiv_restart),
    .tx_empty(tx_empty), .tx_full(tx_full), .rx_empty(rx_empty), .rx_full(rx_full),
    .tx_stall(tx_stall), .tx_over(tx_over), .rx_under(rx_under), .rx_stall(rx_stall),
    .flevel(flevel), .irq_set(irq_set), .irq_clr(irq_clr),
    .gpio_sync_bypass(gpio_sync_bypass),
    .sm_clkdiv(sm_clkdiv), .sm_execctrl(sm_execctrl),
    .sm_shiftctrl(sm_shiftctrl), .sm_pinctrl(sm_pinctrl),
    .sm_instr(sm_instr), .sm_instr_wr(sm_instr_wr),
`ifdef PIO_REGFILE_WRERR_EN
    .wr_err(wr_err),
`endif
    .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic exp_vld = 1'b0;
  bit checking = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] e);
    rd_en = 1'b1; rd_addr = a;
    sb.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  // A read requested in cycle N must be valid in N+1 only; reset cancels it
  always @(posedge clk) exp_vld <= rd_en & ~rst;

  always @(negedge clk) begin
    if (checking) begin
      chk("rd_valid", 32'(rd_valid), 32'(exp_vld));
      if (rd_valid) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("rd_data", rd_data, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    rst = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 32'hF; rd_en = 1'b1; rd_addr = '0;
    tx_empty = 4'hF; tx_full = 4'h0; rx_empty = 4'hF; rx_full = 4'h0;
    tx_stall = '0; tx_over = '0; rx_under = '0; rx_stall = '0;
    flevel = 32'h1234_5678; irq_set = '0; irq_clr = '0;
    tick();
    checking = 1'b1;
    tick(); tick();
    chk("rst_sm_en", 32'(sm_en), 32'h0);
    chk("rst_sm_restart", 32'(sm_restart), 32'h0);
    chk("rst_clkdiv_restart", 32'(clkdiv_restart), 32'h0);
    chk("rst_irq_out", 32'(irq_out), 32'h0);
    chk("rst_instr_wr", 32'(sm_instr_wr), 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_bypass", gpio_sync_bypass, 32'h0);
    chk("rst_clkdiv3", sm_clkdiv[127:96], 32'h0001_0000);
    chk("rst_exec1", sm_execctrl[63:32], 32'h0001_F000);
    chk("rst_shift2", sm_shiftctrl[95:64], 32'h000C_0000);
    chk("rst_pin0", sm_pinctrl[31:0], 32'h1400_0000);
    chk("rst_instr", sm_instr[31:0], 32'h0);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tick();

    // Reset values of every mapped register, back-to-back reads
    rd(9'h000, 32'h0);
    rd(9'h004, 32'h0F00_0F00);
    rd(9'h008, 32'h0);
    rd(9'h00C, 32'h1234_5678);
    rd(9'h030, 32'h0);
    rd(9'h038, 32'h0);
    rd(9'h044, 32'h0000_0004);
    rd(9'h128, 32'h0000_00F0);
    for (int a = 'h12C; a <= 'h140; a += 4) rd(AW'(a), 32'h0);
    for (int i = 0; i < NSM; i++) begin
      b = 'hC8 + 'h18 * i;
      rd(AW'(b),      32'h0001_0000);
      rd(AW'(b + 4),  32'h0001_F000);
      rd(AW'(b + 8),  32'h000C_0000);
      rd(AW'(b + 12), 32'h0);
      rd(AW'(b + 16), 32'h0);
      rd(AW'(b + 20), 32'h1400_0000);
    end
    rd(9'h010, 32'h0);
    rd(9'h1FC, 32'h0);
    tick();

    // CTRL: enables stick, restart bits pulse once
    wr(9'h000, 32'h0000_0F35);
    chk("ctrl_sm_en", 32'(sm_en), 32'h5);
    chk("ctrl_restart", 32'(sm_restart), 32'h3);
    chk("ctrl_clkdiv_restart", 32'(clkdiv_restart), 32'hF);
    tick();
    chk("ctrl_restart_end", 32'(sm_restart), 32'h0);
    chk("ctrl_clkdiv_restart_end", 32'(clkdiv_restart), 32'h0);
    chk("ctrl_sm_en_hold", 32'(sm_en), 32'h5);
    rd(9'h000, 32'h5);

    // FDEBUG: event beats a same-cycle clear
    tx_over = 4'b0100;
    wr(9'h008, 32'h0004_0000);
    tx_over = '0;
    rd(9'h008, 32'h0004_0000);
    wr(9'h008, 32'h0004_0000);
    rd(9'h008, 32'h0);
    rx_stall = 4'b0010; tx_stall = 4'b1000;
    tick();
    rx_stall = '0; tx_stall = '0;
    rd(9'h008, 32'h0800_0002);
    wr(9'h008, 32'h0000_0002);
    rd(9'h008, 32'h0800_0000);

    // INSTR strobes, including back-to-back writes
    wr(9'h0F0, 32'h0000_E081);
    chk("instr_wr_sm1", 32'(sm_instr_wr), 32'h2);
    chk("sm1_instr", 32'(sm_instr[31:16]), 32'hE081);
    tick();
    chk("instr_wr_end", 32'(sm_instr_wr), 32'h0);
    wr_en = 1'b1; wr_addr = 9'h0D8; wr_data = 32'h0000_1111;
    tick();
    chk("instr_wr_sm0", 32'(sm_instr_wr), 32'h1);
    chk("sm0_instr", 32'(sm_instr[15:0]), 32'h1111);
    wr_addr = 9'h108; wr_data = 32'h0000_2222;
    tick();
    wr_en = 1'b0;
    chk("instr_wr_sm2", 32'(sm_instr_wr), 32'h4);
    chk("sm2_instr", 32'(sm_instr[47:32]), 32'h2222);
    tick();
    chk("instr_wr_idle", 32'(sm_instr_wr), 32'h0);
    rd(9'h0F0, 32'h0000_E081);

    // IRQ flags and aggregation
    wr(9'h12C, 32'h0000_0100);
    irq_set = 8'h01;
    tick();
    irq_set = '0;
    chk("irq0_lag", 32'(irq_out[0]), 32'h0);
    tick();
    chk("irq0_set", 32'(irq_out[0]), 32'h1);
    rd(9'h030, 32'h1);
    rd(9'h134, 32'h0000_0100);
    rd(9'h128, 32'h0000_01F0);
    wr(9'h030, 32'h1);
    tick();
    chk("irq0_clr", 32'(irq_out[0]), 32'h0);
    rd(9'h030, 32'h0);
    irq_set = 8'h80; irq_clr = 8'h80;
    tick();
    irq_set = '0; irq_clr = '0;
    rd(9'h030, 32'h80);
    irq_clr = 8'h80;
    tick();
    irq_clr = '0;
    rd(9'h030, 32'h0);
    wr(9'h138, 32'hFFFF_FFFF);
    rd(9'h138, 32'h0000_0FFF);
    wr(9'h138, 32'h0000_0001);
    wr(9'h13C, 32'h0000_0001);
    tick();
    chk("irq1_intf", 32'(irq_out), 32'h2);
    rd(9'h140, 32'h1);
    wr(9'h13C, 32'h0);
    tick();
    chk("irq1_clr", 32'(irq_out[1]), 32'h0);

    // Field masks and read-only SM ADDR
    wr(9'h0F8, 32'hFFFF_FFFF);
    rd(9'h0F8, 32'hFFFF_FF00);
    chk("clkdiv2_out", sm_clkdiv[95:64], 32'hFFFF_FF00);
    wr(9'h114, 32'hFFFF_FFFF);
    rd(9'h114, 32'h7FFF_FF9F);
    wr(9'h0D0, 32'hFFFF_FFFF);
    rd(9'h0D0, 32'hFFFF_0000);
    wr(9'h0F4, 32'hDEAD_BEEF);
    rd(9'h0F4, 32'hDEAD_BEEF);
    chk("pin1_out", sm_pinctrl[63:32], 32'hDEAD_BEEF);
    wr(9'h0D4, 32'hFFFF_FFFF);
    rd(9'h0D4, 32'h0);

    // Same-cycle read and write of one address returns the old value
    wr_en = 1'b1; wr_addr = 9'h038; wr_data = 32'hA5A5_A5A5;
    rd_en = 1'b1; rd_addr = 9'h038; sb.push_back(32'h0);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("bypass_out", gpio_sync_bypass, 32'hA5A5_A5A5);
    rd(9'h03B, 32'hA5A5_A5A5);
    tick();
    chk("rd_hold", rd_data, 32'hA5A5_A5A5);

    // Writes to RO / unmapped addresses are dropped
    wr(9'h004, 32'hFFFF_FFFF);
`ifdef PIO_REGFILE_WRERR_EN
    chk("wr_err_ro", 32'(wr_err), 32'h1);
`endif
    rd(9'h004, 32'h0F00_0F00);
    wr(9'h0C4, 32'h0000_1234);
`ifdef PIO_REGFILE_WRERR_EN
    chk("wr_err_unmapped", 32'(wr_err), 32'h1);
`endif
    rd(9'h0C4, 32'h0);
    wr(9'h038, 32'h0000_005A);
`ifdef PIO_REGFILE_WRERR_EN
    chk("wr_err_ok", 32'(wr_err), 32'h0);
    rd(9'h044, 32'h8000_0004);
    wr(9'h044, 32'h8000_0000);
    rd(9'h044, 32'h0000_0004);
`else
    rd(9'h044, 32'h0000_0004);
`endif

    // Reset in the middle of traffic beats the write and the read
    wr(9'h000, 32'h0000_000A);
    chk("pre_rst_sm_en", 32'(sm_en), 32'hA);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 9'h000; wr_data = 32'hF;
    rd_en = 1'b1; rd_addr = 9'h038;
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("midrst_sm_en", 32'(sm_en), 32'h0);
    chk("midrst_vld", 32'(rd_valid), 32'h0);
    chk("midrst_pin1", sm_pinctrl[63:32], 32'h1400_0000);
    rd(9'h038, 32'h0);
    tick(); tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
